pipe_stage_skid: RTL

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 99 +++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid buffer so in_ready can be registered.
// Control fields are zeroed whenever the stage empties or is flushed; payload optionally held.
module pipe_stage_skid #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned CNT_W      = 8,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t state, nstate;
  entry_t main_q, skid_q, in_e;
  logic   in_fire, out_fire;

  assign in_e     = '{ctrl: in_ctrl, data: in_data};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_ctrl = main_q.ctrl;
  assign out_data = main_q.data;

  always_comb begin
    nstate = state;
    if (flush) nstate = EMPTY;
    else begin
      unique case (state)
        EMPTY: if (in_fire) nstate = BUSY;
        BUSY: begin
          if (in_fire && !out_fire)      nstate = FULL;
          else if (!in_fire && out_fire) nstate = EMPTY;
        end
        FULL:    if (out_fire) nstate = BUSY;
        default: nstate = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      stall_cnt <= '0;
    end else begin
      state     <= nstate;
      // Handshake flags are registered copies of the next-state decode.
      in_ready  <= (nstate != FULL);
      out_valid <= (nstate != EMPTY);
      occupancy <= nstate;
      if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) begin
        main_q.ctrl <= '0;
        skid_q.ctrl <= '0;
        if (CLEAR_DATA) begin
          main_q.data <= '0;
          skid_q.data <= '0;
        end
      end else begin
        unique case (state)
          EMPTY: if (in_fire) main_q <= in_e;
          BUSY: begin
            if (in_fire && !out_fire)     skid_q <= in_e;
            else if (in_fire && out_fire) main_q <= in_e;
            else if (out_fire) begin
              main_q.ctrl <= '0;
              if (CLEAR_DATA) main_q.data <= '0;
            end
          end
          FULL:    if (out_fire) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

endmodule
